// File: rtl/freq_meter_if.sv
// Measurement bus of the frequency meter.
//   sig_in     : slow square wave under test (asynchronous to clk)
//   period     : last complete rising-to-rising period, clk cycles
//   high_time  : high-phase length of that period, clk cycles
//   valid      : one-cycle pulse when period/high_time/freq_class update
//   freq_class : 00 unknown, 01 1 Hz, 10 4 Hz, 11 no signal
//   timeout    : high while no rising edge has been seen for too long
// master = the meter, slave = the consumer that owns sig_in.
interface freq_meter_if #(
   parameter int unsigned PERIOD_W = 32
);
   logic                sig_in;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] high_time;
   logic                valid;
   logic [1:0]          freq_class;
   logic                timeout;

   modport master (
      input  sig_in,
      output period, high_time, valid, freq_class, timeout
   );

   modport slave (
      output sig_in,
      input  period, high_time, valid, freq_class, timeout
   );
endinterface

// File: rtl/freq_meter.sv
// Period / high-time meter for a slow square wave with 1 Hz / 4 Hz
// classification and loss-of-signal detection.
//   clk : system clock, all logic on its rising edge
//   rst : synchronous active-high reset
//   bus : freq_meter_if.master (sig_in in; period, high_time, valid,
//         freq_class, timeout out; all outputs registered)
module freq_meter #(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned PERIOD_W  = 32,
   parameter int unsigned TOL_SHIFT = 6
) (
   input  logic         clk,
   input  logic         rst,
   freq_meter_if.master bus
);

   localparam int unsigned TIMEOUT_CYC = 2 * CLK_FREQ;
   localparam int unsigned TCNT_W      = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned Q_FREQ      = CLK_FREQ / 4;
   localparam int unsigned CW          = PERIOD_W + 1;

   // Classification windows, inclusive, one bit wider than the counters
   localparam logic [CW-1:0] HZ1_LO = CW'(CLK_FREQ - (CLK_FREQ >> TOL_SHIFT));
   localparam logic [CW-1:0] HZ1_HI = CW'(CLK_FREQ + (CLK_FREQ >> TOL_SHIFT));
   localparam logic [CW-1:0] HZ4_LO = CW'(Q_FREQ - (Q_FREQ >> TOL_SHIFT));
   localparam logic [CW-1:0] HZ4_HI = CW'(Q_FREQ + (Q_FREQ >> TOL_SHIFT));

   localparam logic [1:0] CLS_UNKNOWN = 2'b00;
   localparam logic [1:0] CLS_1HZ     = 2'b01;
   localparam logic [1:0] CLS_4HZ     = 2'b10;
   localparam logic [1:0] CLS_LOST    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOST    = 2'd2
   } state_t;

   state_t              state;
   logic                s1, s2, s3;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] hcnt;
   logic [TCNT_W-1:0]   tcnt;
   logic [PERIOD_W-1:0] period_q;
   logic [PERIOD_W-1:0] high_q;
   logic                valid_q;
   logic [1:0]          class_q;
   logic                timeout_q;

   logic                rise_c;
   logic                cnt_sat_c;
   logic                hcnt_sat_c;
   logic                tcnt_hit_c;
   logic [CW-1:0]       cnt_ext_c;
   logic [1:0]          class_c;

   // Edge detect on the synchronized input
   assign rise_c     = s2 & ~s3;
   assign cnt_sat_c  = &cnt;
   assign hcnt_sat_c = &hcnt;
   // tcnt counts cycles since the last rise (since reset while idle)
   assign tcnt_hit_c = (tcnt == TCNT_W'(TIMEOUT_CYC));
   assign cnt_ext_c  = {1'b0, cnt};

   // Class of the period being closed by the current rise
   always_comb begin
      class_c = CLS_UNKNOWN;
      if ((cnt_ext_c >= HZ1_LO) && (cnt_ext_c <= HZ1_HI)) begin
         class_c = CLS_1HZ;
      end else if ((cnt_ext_c >= HZ4_LO) && (cnt_ext_c <= HZ4_HI)) begin
         class_c = CLS_4HZ;
      end
   end

   // Synchronizer, measurement FSM and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         cnt       <= '0;
         hcnt      <= '0;
         tcnt      <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         class_q   <= CLS_UNKNOWN;
         timeout_q <= 1'b0;
      end else begin
         s1      <= bus.sig_in;
         s2      <= s1;
         s3      <= s2;
         valid_q <= 1'b0;

         case (state)
            // Waiting for a reference rise; nothing to report yet
            ST_IDLE: begin
               if (rise_c) begin
                  state <= ST_MEASURE;
                  cnt   <= PERIOD_W'(1);
                  hcnt  <= PERIOD_W'(1);
                  tcnt  <= TCNT_W'(1);
               end else if (tcnt_hit_c) begin
                  state     <= ST_LOST;
                  timeout_q <= 1'b1;
                  class_q   <= CLS_LOST;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end

            // A rise closes the running period; a rise on the threshold
            // cycle wins over the timeout
            ST_MEASURE: begin
               if (rise_c) begin
                  period_q <= cnt;
                  high_q   <= hcnt;
                  class_q  <= class_c;
                  valid_q  <= 1'b1;
                  cnt      <= PERIOD_W'(1);
                  hcnt     <= PERIOD_W'(1);
                  tcnt     <= TCNT_W'(1);
               end else if (tcnt_hit_c) begin
                  state     <= ST_LOST;
                  timeout_q <= 1'b1;
                  class_q   <= CLS_LOST;
               end else begin
                  if (!cnt_sat_c) begin
                     cnt <= cnt + PERIOD_W'(1);
                  end
                  if (s2 && !hcnt_sat_c) begin
                     hcnt <= hcnt + PERIOD_W'(1);
                  end
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end

            // Recovery rise only re-arms; the partial period is dropped
            // and freq_class keeps reporting loss until the next valid
            ST_LOST: begin
               if (rise_c) begin
                  state     <= ST_MEASURE;
                  timeout_q <= 1'b0;
                  cnt       <= PERIOD_W'(1);
                  hcnt      <= PERIOD_W'(1);
                  tcnt      <= TCNT_W'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.period     = period_q;
   assign bus.high_time  = high_q;
   assign bus.valid      = valid_q;
   assign bus.freq_class = class_q;
   assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: directed waveforms plus randomized
// square waves, checked every cycle against an edge-timestamp model.
module tb_freq_meter;

   localparam int unsigned CLK_FREQ  = 400;
   localparam int unsigned PERIOD_W  = 16;
   localparam int unsigned TOL_SHIFT = 6;
   localparam int          TO_CYC    = 2 * int'(CLK_FREQ);
   localparam int          LAT       = 3;
   localparam int          RING      = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;

   freq_meter_if #(.PERIOD_W(PERIOD_W)) bus ();

   freq_meter #(
      .CLK_FREQ (CLK_FREQ),
      .PERIOD_W (PERIOD_W),
      .TOL_SHIFT(TOL_SHIFT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Cycle index: value n during the interval after the n-th posedge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: expected {period, high_time, valid, class, timeout}
   logic [35:0] exp_q [RING];
   int          mode = 0;          // 0 no reference rise, 1 running, 2 lost
   int          last_rise = 0;
   int          last_fall = 0;
   logic        prev_v = 1'b0;
   logic [15:0] m_period = '0;
   logic [15:0] m_high = '0;
   logic [1:0]  m_class = '0;
   logic        m_timeout = 1'b0;

   function automatic logic [1:0] classify(input int p);
      int f  = int'(CLK_FREQ);
      int t1 = f >> TOL_SHIFT;
      int q  = f / 4;
      int tq = q >> TOL_SHIFT;
      if (p >= f - t1 && p <= f + t1) return 2'b01;
      if (p >= q - tq && p <= q + tq) return 2'b10;
      return 2'b00;
   endfunction

   // Input seen at drive cycle n becomes visible on the outputs at n+LAT
   task automatic model_step(input int n, input logic v, input logic r);
      logic mv;
      mv = 1'b0;
      if (r) begin
         mode      = 0;
         prev_v    = 1'b0;
         m_period  = '0;
         m_high    = '0;
         m_class   = '0;
         m_timeout = 1'b0;
         for (int d = 1; d <= LAT; d++) exp_q[(n + d) % RING] = '0;
      end else begin
         if (v && !prev_v) begin
            if (mode == 1) begin
               m_period = 16'(n - last_rise);
               m_high   = 16'(last_fall - last_rise);
               m_class  = classify(n - last_rise);
               mv       = 1'b1;
            end
            if (mode == 2) m_timeout = 1'b0;
            mode      = 1;
            last_rise = n;
         end else if (mode == 1 && (n - last_rise) == TO_CYC) begin
            mode      = 2;
            m_timeout = 1'b1;
            m_class   = 2'b11;
         end
         if (!v && prev_v) last_fall = n;
         prev_v = v;
         exp_q[(n + LAT) % RING] = {m_period, m_high, mv, m_class, m_timeout};
      end
   endtask

   task automatic drive(input logic v, input logic r);
      @(posedge clk);
      #1;
      rst        = r;
      bus.sig_in = v;
      model_step(cyc, v, r);
   endtask

   task automatic wave(input int hi, input int lo, input int n);
      repeat (n) begin
         repeat (hi) drive(1'b1, 1'b0);
         repeat (lo) drive(1'b0, 1'b0);
      end
   endtask

   // Per-cycle monitor, sampled on the falling edge
   logic        mon_en = 1'b0;
   int          n_valid = 0;
   logic [15:0] lv_period = '0;
   logic [15:0] lv_high = '0;
   logic [1:0]  lv_class = '0;
   logic        prev_to = 1'b0;
   int          to_cyc = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         check("outputs",
               64'({bus.period, bus.high_time, bus.valid, bus.freq_class, bus.timeout}),
               64'(exp_q[cyc % RING]));
         if (bus.valid === 1'b1) begin
            n_valid++;
            lv_period = bus.period;
            lv_high   = bus.high_time;
            lv_class  = bus.freq_class;
         end
         if (bus.timeout === 1'b1 && prev_to !== 1'b1) to_cyc = cyc;
         prev_to = bus.timeout;
      end
   end

   int targets[9] = '{98, 99, 100, 101, 102, 393, 394, 406, 407};

   initial begin
      int nv0;
      int r0;
      bus.sig_in = 1'b0;
      repeat (3) drive(1'b0, 1'b1);
      mon_en = 1'b1;
      drive(1'b0, 1'b0);

      check("rst_period",  64'(bus.period),     64'(0));
      check("rst_high",    64'(bus.high_time),  64'(0));
      check("rst_valid",   64'(bus.valid),      64'(0));
      check("rst_class",   64'(bus.freq_class), 64'(0));
      check("rst_timeout", 64'(bus.timeout),    64'(0));

      // 1 Hz wave: first rise only arms, then one valid per period
      nv0 = n_valid;
      wave(200, 200, 5);
      check("hz1_nvalid", 64'(n_valid - nv0), 64'(4));
      check("hz1_period", 64'(lv_period), 64'(400));
      check("hz1_high",   64'(lv_high),   64'(200));
      check("hz1_class",  64'(lv_class),  64'(1));

      // 4 Hz wave and classification boundaries
      wave(25, 75, 4);
      check("hz4_period", 64'(lv_period), 64'(100));
      check("hz4_high",   64'(lv_high),   64'(25));
      check("hz4_class",  64'(lv_class),  64'(2));
      wave(25, 77, 2);
      check("p102_period", 64'(lv_period), 64'(102));
      check("p102_class",  64'(lv_class),  64'(0));
      wave(200, 206, 2);
      check("p406_period", 64'(lv_period), 64'(406));
      check("p406_class",  64'(lv_class),  64'(1));
      wave(200, 207, 2);
      check("p407_period", 64'(lv_period), 64'(407));
      check("p407_class",  64'(lv_class),  64'(0));

      // Signal lost: timeout 800 cycles after the last synchronized rise
      nv0 = n_valid;
      drive(1'b1, 1'b0);
      r0 = cyc;
      repeat (199) drive(1'b1, 1'b0);
      repeat (700) drive(1'b0, 1'b0);
      check("lost_nvalid",  64'(n_valid - nv0),  64'(1));
      check("lost_timeout", 64'(bus.timeout),    64'(1));
      check("lost_class",   64'(bus.freq_class), 64'(3));
      check("lost_period",  64'(bus.period),     64'(407));
      check("lost_latency", 64'(to_cyc - r0),    64'(TO_CYC + LAT));

      // Recovery: first rise clears timeout without a valid
      nv0 = n_valid;
      wave(25, 75, 3);
      check("rec_nvalid",  64'(n_valid - nv0), 64'(2));
      check("rec_class",   64'(lv_class),      64'(2));
      check("rec_timeout", 64'(bus.timeout),   64'(0));

      // Rise exactly on the threshold cycle
      wave(25, 775, 1);
      repeat (5) drive(1'b1, 1'b0);
      check("thr_period",  64'(lv_period),   64'(800));
      check("thr_class",   64'(lv_class),    64'(0));
      check("thr_timeout", 64'(bus.timeout), 64'(0));
      repeat (95) drive(1'b0, 1'b0);

      // Reset 150 cycles into a 400-cycle period
      wave(200, 200, 2);
      repeat (150) drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b1);
      check("mid_rst_outputs",
            64'({bus.period, bus.high_time, bus.valid, bus.freq_class, bus.timeout}),
            64'(0));
      nv0 = n_valid;
      wave(200, 200, 3);
      check("mid_rst_nvalid", 64'(n_valid - nv0), 64'(2));
      check("mid_rst_period", 64'(lv_period),     64'(400));

      // Randomized waves, boundary periods, losses and resets
      for (int it = 0; it < 40; it++) begin
         int hi, lo, n, sel, tgt;
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            tgt = targets[$urandom_range(0, 8)];
            hi  = tgt / 3 + 1;
            lo  = tgt - hi;
            n   = 2;
         end else begin
            hi = int'($urandom_range(1, 150));
            lo = int'($urandom_range(1, 250));
            n  = int'($urandom_range(1, 3));
         end
         wave(hi, lo, n);
         if (sel == 8) repeat ($urandom_range(700, 850)) drive(1'b0, 1'b0);
         if (sel == 9) repeat ($urandom_range(1, 3)) drive(1'b0, 1'b1);
      end
      repeat (5) drive(1'b0, 1'b0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter PERIOD_W, default 32, meaning the width of the period and high-time counters and outputs.
REQ-003 SHALL have parameter TOL_SHIFT, default 6, meaning the classification tolerance is expected_period >> TOL_SHIFT cycles.
REQ-004 SHALL have port clk, input, 1, system clock; one clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port sig_in, input, 1, asynchronous slow square wave under test (e.g. a divided 1 Hz / 4 Hz clock).
REQ-007 SHALL have port period, output, PERIOD_W, last complete rising-to-rising period in clk cycles.
REQ-008 SHALL have port high_time, output, PERIOD_W, high-phase length of that same period in clk cycles.
REQ-009 SHALL have port valid, output, 1, one-cycle pulse when period/high_time/freq_class update.
REQ-010 SHALL have port freq_class, output, 2, where 00 = unknown, 01 = 1 Hz, 10 = 4 Hz, 11 = no signal (timeout).
REQ-011 SHALL have port timeout, output, 1, level that is high while no rising edge has been seen for TIMEOUT_CYC = 2*CLK_FREQ cycles.

Function
REQ-012 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-013 SHALL implement the states IDLE, MEASURE and LOST.
- IDLE: waiting for the first rise after reset.
- MEASURE: counting a period.
- LOST: timeout.
REQ-014 SHALL transition IDLE->MEASURE on rise; load cnt=1 and hcnt=1; no valid.
REQ-015 SHALL, in MEASURE, increment cnt every cycle without rise, and increment hcnt while s2=1.
REQ-016 SHALL, on rise in MEASURE, latch period=cnt and high_time=hcnt, pulse valid in the next cycle, and reload cnt=1, hcnt=1. Edges N cycles apart give period=N.
REQ-017 SHALL make outputs visible in the same cycle valid is high, and hold them until the next update.
REQ-018 SHALL classify the latched period as follows:
- Within CLK_FREQ ± (CLK_FREQ>>TOL_SHIFT), inclusive -> 01.
- Within CLK_FREQ/4 ± ((CLK_FREQ/4)>>TOL_SHIFT), inclusive -> 10.
- Otherwise -> 00.
REQ-019 SHALL compute the classification comparisons in PERIOD_W+1 bits so that no wrap occurs at the bounds.
REQ-020 SHALL saturate cnt and hcnt at 2^PERIOD_W-1; they never wrap.
REQ-021 SHALL transition MEASURE->LOST or IDLE->LOST when cycles without rise reach TIMEOUT_CYC.
- On entry: timeout=1, freq_class=11, no valid pulse, period/high_time retained.
REQ-022 SHALL transition LOST->MEASURE on rise.
- timeout clears in the same cycle as the transition.
- freq_class stays 11 until the next valid.
- The first partial period after recovery is discarded (no valid).
REQ-023 SHALL treat a rise coinciding with the timeout threshold cycle as rise (no LOST entry).
REQ-024 SHALL filter glitches shorter than one clk only by synchronization; every synchronized rise counts as an edge.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set state=IDLE and clear s1/s2/s3, cnt, hcnt, period, high_time, valid, freq_class and timeout to 0.
REQ-026 SHALL, on rst asserted mid-MEASURE, discard the in-progress period; the first valid after reset requires two post-reset rises.
REQ-027 SHALL have rst take priority over every other event in the same cycle.

Verification (CLK_FREQ=400, PERIOD_W=16, TOL_SHIFT=6; 1 Hz period 400 ± 6, 4 Hz period 100 ± 1)
REQ-028 SHALL be verified with a square wave of period 400, 200 high -> after the 2nd rise, valid pulses once per 400 cycles; period=400, high_time=200, freq_class=01.
REQ-029 SHALL be verified with period 100, 25 high -> period=100, high_time=25, freq_class=10; then period 102 -> freq_class=00; then period 406 -> 01; then period 407 -> 00.
REQ-030 SHALL be verified by holding sig_in low for 800 cycles after a valid -> timeout=1 and freq_class=11 exactly 800 cycles after the last rise; period unchanged; no valid.
REQ-031 SHALL be verified by resuming a 100-cycle wave from LOST -> timeout=0 on the first rise, no valid for the first rise, and valid with freq_class=10 on the second rise.
REQ-032 SHALL be verified by asserting rst 150 cycles into a 400-cycle period -> all outputs 0 the next cycle, and no valid until two rises after rst deasserts.
REQ-033 SHALL be verified by placing a rise exactly at cycle 800 after the previous rise -> no timeout, valid with period=800 and freq_class=00.
